// File: rtl/player_motion_tracker.sv
// Player motion tracker: averages accelerometer tilt and, once per frame,
// integrates it into a clamped on-screen player centre for the VGA block.
module player_motion_tracker #(
    parameter int WIDTH     = 640,
    parameter int HEIGHT    = 480,
    parameter int HALF_SIZE = 20,
    parameter int DEADZONE  = 64,
    parameter int VEL_SHIFT = 5,
    parameter int MAX_VEL   = 8
) (
    input  logic        clk_25mHz,
    input  logic        reset,
    input  logic        sample_valid,
    output logic        sample_ready,
    input  logic [11:0] accel_raw_x,
    input  logic [11:0] accel_raw_y,
    input  logic        frame_tick,
    input  logic [31:0] game_state,
    input  logic        recenter,
    output logic [31:0] player_x,
    output logic [31:0] player_y,
    output logic        pos_valid
);

    typedef enum logic [1:0] {TRACK, CALC, APPLY} state_t;

    localparam logic signed [11:0] X_CTR = 12'(WIDTH / 2);
    localparam logic signed [11:0] Y_CTR = 12'(HEIGHT / 2);
    localparam logic signed [11:0] X_MIN = 12'(HALF_SIZE);
    localparam logic signed [11:0] X_MAX = 12'(WIDTH - 1 - HALF_SIZE);
    localparam logic signed [11:0] Y_MIN = 12'(HALF_SIZE);
    localparam logic signed [11:0] Y_MAX = 12'(HEIGHT - 1 - HALF_SIZE);
    localparam logic signed [11:0] DZ    = 12'(DEADZONE);
    localparam logic signed [11:0] VMAX  = 12'(MAX_VEL);

    state_t state, state_nx;

    logic signed [11:0] hist_x [4];
    logic signed [11:0] hist_y [4];
    logic signed [11:0] vel_x, vel_y;
    logic signed [11:0] pos_x, pos_y;
    logic signed [11:0] calc_vx, calc_vy;
    logic signed [11:0] next_x, next_y;

    logic running;
    logic accept;
    logic unused_gs;

    assign running   = |game_state[1:0];
    assign accept    = sample_valid && sample_ready && !recenter;
    assign unused_gs = ^game_state[31:2];

    assign player_x = {20'd0, pos_x};
    assign player_y = {20'd0, pos_y};

    // Averaged tilt -> dead-zoned, shifted and saturated velocity.
    function automatic logic signed [11:0] tilt_vel(
        input logic signed [11:0] a,
        input logic signed [11:0] b,
        input logic signed [11:0] c,
        input logic signed [11:0] d
    );
        logic signed [13:0] sum;
        logic signed [11:0] avg;
        logic signed [11:0] v;
        sum = {{2{a[11]}}, a} + {{2{b[11]}}, b}
            + {{2{c[11]}}, c} + {{2{d[11]}}, d};
        avg = sum[13:2];
        if (avg > -DZ && avg < DZ) v = '0;
        else v = avg >>> VEL_SHIFT;
        if (v > VMAX) v = VMAX;
        else if (v < -VMAX) v = -VMAX;
        return v;
    endfunction

    function automatic logic signed [11:0] clamp(
        input logic signed [11:0] p,
        input logic signed [11:0] lo,
        input logic signed [11:0] hi
    );
        if (p < lo) return lo;
        if (p > hi) return hi;
        return p;
    endfunction

    // Per-axis velocity from history and clamped next position.
    always_comb begin
        calc_vx = tilt_vel(hist_x[0], hist_x[1], hist_x[2], hist_x[3]);
        calc_vy = tilt_vel(hist_y[0], hist_y[1], hist_y[2], hist_y[3]);
        next_x  = clamp(pos_x + vel_x, X_MIN, X_MAX);
        next_y  = clamp(pos_y + vel_y, Y_MIN, Y_MAX);
    end

    // State register.
    always_ff @(posedge clk_25mHz or negedge reset) begin
        if (!reset) state <= TRACK;
        else state <= state_nx;
    end

    // Next-state logic; recenter and idle always fall back to TRACK.
    always_comb begin
        state_nx = state;
        if (recenter || !running) begin
            state_nx = TRACK;
        end else begin
            unique case (state)
                TRACK:   if (frame_tick) state_nx = CALC;
                CALC:    state_nx = APPLY;
                APPLY:   state_nx = TRACK;
                default: state_nx = TRACK;
            endcase
        end
    end

    // Outputs decoded from state: history only moves while tracking.
    always_comb begin
        sample_ready = (state == TRACK);
    end

    // Sample history, velocity and position datapath.
    always_ff @(posedge clk_25mHz or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                hist_x[i] <= '0;
                hist_y[i] <= '0;
            end
            vel_x     <= '0;
            vel_y     <= '0;
            pos_x     <= X_CTR;
            pos_y     <= Y_CTR;
            pos_valid <= 1'b0;
        end else begin
            pos_valid <= 1'b0;
            if (recenter) begin
                for (int i = 0; i < 4; i++) begin
                    hist_x[i] <= '0;
                    hist_y[i] <= '0;
                end
                pos_x     <= X_CTR;
                pos_y     <= Y_CTR;
                pos_valid <= 1'b1;
            end else begin
                if (accept) begin
                    for (int i = 3; i > 0; i--) begin
                        hist_x[i] <= hist_x[i-1];
                        hist_y[i] <= hist_y[i-1];
                    end
                    hist_x[0] <= accel_raw_x;
                    hist_y[0] <= accel_raw_y;
                end
                if (!running) begin
                    pos_x <= X_CTR;
                    pos_y <= Y_CTR;
                end else if (state == CALC) begin
                    vel_x <= calc_vx;
                    vel_y <= calc_vy;
                end else if (state == APPLY) begin
                    pos_x     <= next_x;
                    pos_y     <= next_y;
                    pos_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_player_motion_tracker.sv
// Directed bench for player_motion_tracker with a model-fed scoreboard.
// Expected positions are queued at frame_tick and popped on pos_valid.
module tb_player_motion_tracker;

    logic        clk_25mHz = 1'b0;
    logic        reset;
    logic        sample_valid;
    logic        sample_ready;
    logic [11:0] accel_raw_x;
    logic [11:0] accel_raw_y;
    logic        frame_tick;
    logic [31:0] game_state;
    logic        recenter;
    logic [31:0] player_x;
    logic [31:0] player_y;
    logic        pos_valid;

    player_motion_tracker dut (
        .clk_25mHz   (clk_25mHz),
        .reset       (reset),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .accel_raw_x (accel_raw_x),
        .accel_raw_y (accel_raw_y),
        .frame_tick  (frame_tick),
        .game_state  (game_state),
        .recenter    (recenter),
        .player_x    (player_x),
        .player_y    (player_y),
        .pos_valid   (pos_valid)
    );

    always #20 clk_25mHz = ~clk_25mHz;

    typedef struct {
        int x;
        int y;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   mhx[4];
    int   mhy[4];
    int   mx = 320;
    int   my = 240;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int fdiv(input int a, input int d);
        if (a >= 0) return a / d;
        return -((-a + d - 1) / d);
    endfunction

    function automatic int model_vel(input int a, input int b,
                                     input int c, input int d);
        int avg;
        int v;
        avg = fdiv(a + b + c + d, 4);
        if (avg > -64 && avg < 64) return 0;
        v = fdiv(avg, 32);
        if (v > 8) v = 8;
        if (v < -8) v = -8;
        return v;
    endfunction

    function automatic int lim(input int p, input int lo, input int hi);
        if (p < lo) return lo;
        if (p > hi) return hi;
        return p;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 4; i++) begin
            mhx[i] = 0;
            mhy[i] = 0;
        end
        mx = 320;
        my = 240;
    endtask

    task automatic send(input int x, input int y);
        sample_valid = 1'b1;
        accel_raw_x  = 12'(x);
        accel_raw_y  = 12'(y);
        @(negedge clk_25mHz);
        sample_valid = 1'b0;
        for (int i = 3; i > 0; i--) begin
            mhx[i] = mhx[i-1];
            mhy[i] = mhy[i-1];
        end
        mhx[0] = x;
        mhy[0] = y;
    endtask

    task automatic do_frame(input string tag);
        exp_t e;
        exp_t got;
        int   n;
        logic rdy2;
        mx = lim(mx + model_vel(mhx[0], mhx[1], mhx[2], mhx[3]), 20, 619);
        my = lim(my + model_vel(mhy[0], mhy[1], mhy[2], mhy[3]), 20, 459);
        e.x = mx;
        e.y = my;
        sb.push_back(e);
        frame_tick = 1'b1;
        @(negedge clk_25mHz);
        frame_tick = 1'b0;
        n = 1;
        check({tag, "_rdy_calc"}, 32'(sample_ready), 32'd0);
        rdy2 = 1'b1;
        while (!pos_valid && n < 8) begin
            @(negedge clk_25mHz);
            n++;
            if (n == 2) rdy2 = sample_ready;
        end
        check({tag, "_latency"}, 32'(n), 32'd3);
        check({tag, "_rdy_apply"}, 32'(rdy2), 32'd0);
        got = sb.pop_front();
        check({tag, "_x"}, player_x, 32'(got.x));
        check({tag, "_y"}, player_y, 32'(got.y));
        @(negedge clk_25mHz);
        check({tag, "_pv_drop"}, 32'(pos_valid), 32'd0);
    endtask

    initial begin
        int   saw_pv;
        reset        = 1'b0;
        sample_valid = 1'b0;
        accel_raw_x  = '0;
        accel_raw_y  = '0;
        frame_tick   = 1'b0;
        game_state   = 32'd1;
        recenter     = 1'b0;
        clear_model();
        repeat (3) @(negedge clk_25mHz);
        reset = 1'b1;
        @(negedge clk_25mHz);

        check("rst_x", player_x, 32'd320);
        check("rst_y", player_y, 32'd240);
        check("rst_ready", 32'(sample_ready), 32'd1);
        check("rst_pv", 32'(pos_valid), 32'd0);

        // Strong +X tilt saturates velocity at 8.
        repeat (4) send(512, 0);
        do_frame("sat8");
        check("sat8_model_x", player_x, 32'd328);

        // Small tilts inside the dead zone leave position unchanged.
        repeat (4) send(40, -60);
        do_frame("dz");
        check("dz_model", player_x, 32'd328);

        // Full-scale tilt drives both axes into their bounds.
        repeat (4) send(2047, -2048);
        for (int f = 0; f < 40; f++) do_frame("edge");
        check("edge_x", player_x, 32'd619);
        check("edge_y", player_y, 32'd20);

        // Idle: position snaps to centre, frame ticks ignored.
        game_state = 32'd0;
        mx = 320;
        my = 240;
        saw_pv = 0;
        for (int k = 0; k < 3; k++) begin
            send(700, 700);
            frame_tick = 1'b1;
            @(negedge clk_25mHz);
            frame_tick = 1'b0;
            repeat (3) begin
                if (pos_valid) saw_pv++;
                @(negedge clk_25mHz);
            end
        end
        check("idle_pv", 32'(saw_pv), 32'd0);
        check("idle_x", player_x, 32'd320);
        check("idle_y", player_y, 32'd240);
        check("idle_ready", 32'(sample_ready), 32'd1);

        // Running again, walk to x=400, then recenter.
        game_state = 32'h0000_0002;
        repeat (4) send(512, 0);
        for (int f = 0; f < 10; f++) do_frame("walk");
        check("walk_x", player_x, 32'd400);
        recenter     = 1'b1;
        sample_valid = 1'b1;
        accel_raw_x  = 12'd1000;
        accel_raw_y  = 12'd1000;
        @(negedge clk_25mHz);
        recenter     = 1'b0;
        sample_valid = 1'b0;
        clear_model();
        check("rc_x", player_x, 32'd320);
        check("rc_y", player_y, 32'd240);
        check("rc_pv", 32'(pos_valid), 32'd1);
        @(negedge clk_25mHz);
        check("rc_pv_drop", 32'(pos_valid), 32'd0);
        do_frame("rc_zero");
        check("rc_zero_x", player_x, 32'd320);

        // Reset asserted while the FSM is in CALC.
        game_state = 32'd1;
        repeat (4) send(512, 0);
        do_frame("pre_rst");
        check("pre_rst_x", player_x, 32'd328);
        frame_tick = 1'b1;
        @(negedge clk_25mHz);
        frame_tick = 1'b0;
        reset = 1'b0;
        #1;
        clear_model();
        check("mid_rst_x", player_x, 32'd320);
        check("mid_rst_y", player_y, 32'd240);
        check("mid_rst_pv", 32'(pos_valid), 32'd0);
        saw_pv = 0;
        repeat (3) begin
            @(negedge clk_25mHz);
            if (pos_valid) saw_pv++;
        end
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk_25mHz);
            if (pos_valid) saw_pv++;
        end
        check("mid_rst_no_pv", 32'(saw_pv), 32'd0);
        check("post_rst_ready", 32'(sample_ready), 32'd1);
        do_frame("post_rst");
        check("post_rst_x", player_x, 32'd320);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1);
    end

endmodule
